fetch_stage: RTL

- Pipelined instruction-fetch stage: owns the architectural PC, drives the instruction memory, and holds the IF/ID pipeline register consumed by the decode/register-read stage of the cpu datapath.
- Applies stall and flush requests from the hazard unit, and branch/JAL/JR redirects resolved downstream.
- Freezes fetch on HLT while still allowing a speculative HLT to be cancelled by a redirect.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_stage_if_id_reg.sv | 47 ++++
 rtl/fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes used by the front end, the NOP encoding
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [3:0]  OP_B      = 4'hC;
    localparam logic [3:0]  OP_JAL    = 4'hD;
    localparam logic [3:0]  OP_JR     = 4'hE;
    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        BOOT      = 2'b00,
        FETCH     = 2'b01,
        HALT_WAIT = 2'b10
    } fetch_state_e;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with hold and squash; squash inserts a bubble
// (NOP, invalid) while leaving the PC-increment field untouched.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              squash_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_inc_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_inc_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc_inc_q;
    logic              valid_q;

    // Pipeline register: squash beats hold beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= DATA_W'(NOP_INSTR);
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
        end else if (squash_i) begin
            instr_q  <= DATA_W'(NOP_INSTR);
            valid_q  <= 1'b0;
        end else if (hold_i) begin
            instr_q  <= instr_q;
            pc_inc_q <= pc_inc_q;
            valid_q  <= valid_q;
        end else begin
            instr_q  <= instr_i;
            pc_inc_q <= pc_inc_i;
            valid_q  <= 1'b1;
        end
    end

    assign instr_o  = instr_q;
    assign pc_inc_o = pc_inc_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and feeds
// the IF/ID register, honouring stall, redirect and HLT freeze.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] im_instr,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        fetch_halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pc_inc_s;
    logic         hold_s;
    logic         squash_s;

    assign pc_inc_s = pc_q + 16'h0001;

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID control; redirect > stall > sequential.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_s   = 1'b0;
        squash_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d  = FETCH;
                squash_s = 1'b1;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    squash_s = 1'b1;
                end else if (stall) begin
                    hold_s = 1'b1;
                end else if (is_hlt(im_instr)) begin
                    state_d = HALT_WAIT;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            HALT_WAIT: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    squash_s = 1'b1;
                    state_d  = FETCH;
                end else if (stall) begin
                    hold_s = 1'b1;
                end else begin
                    squash_s = 1'b1;
                end
            end
            default: begin
                state_d  = BOOT;
                pc_d     = RESET_PC;
                squash_s = 1'b1;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        im_rd_en     = 1'b0;
        fetch_halted = 1'b0;
        case (state_q)
            FETCH:     im_rd_en = 1'b1;
            HALT_WAIT: fetch_halted = 1'b1;
            default: begin
                im_rd_en     = 1'b0;
                fetch_halted = 1'b0;
            end
        endcase
    end

    assign im_addr = pc_q;
    assign pc      = pc_q;

    if_id_reg #(.DATA_W(16)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (hold_s),
        .squash_i (squash_s),
        .instr_i  (im_instr),
        .pc_inc_i (pc_inc_s),
        .instr_o  (if_id_instr),
        .pc_inc_o (if_id_pc_inc),
        .valid_o  (if_id_valid)
    );

endmodule
